// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Multi-cycle restoring divider controller for MIPS div/divu.
//               Borrows the CPU's shared 32-bit subtractor for the absolute
//               value, trial-subtract and sign-fix steps.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             sub_req,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    output logic             sub_cin,
    input  logic [WIDTH-1:0] sub_s,
    input  logic             sub_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS_A = 3'd1,
        S_ABS_B = 3'd2,
        S_DIV   = 3'd3,
        S_FIX_Q = 3'd4,
        S_FIX_R = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] count;
    logic             neg_a;
    logic             neg_b;

    // The partial remainder is effectively WIDTH+1 bits wide: shift_msb is
    // the bit that falls off the top, and when it is set the trial always
    // succeeds regardless of the subtractor's borrow.
    logic [WIDTH-1:0] shift_val;
    logic             shift_msb;
    logic             trial_ok;

    assign shift_val = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign shift_msb = r_reg[WIDTH-1];
    assign trial_ok  = shift_msb | sub_cout;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sub_req   = 1'b0;
        sub_a     = '0;
        sub_b     = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? S_DONE : S_ABS_A;
                end
            end
            S_ABS_A: begin
                sub_req   = 1'b1;
                sub_b     = q_reg;
                state_nxt = S_ABS_B;
            end
            S_ABS_B: begin
                sub_req   = 1'b1;
                sub_b     = d_reg;
                state_nxt = S_DIV;
            end
            S_DIV: begin
                sub_req = 1'b1;
                sub_a   = shift_val;
                sub_b   = d_reg;
                if (count == LAST_STEP) begin
                    state_nxt = S_FIX_Q;
                end
            end
            S_FIX_Q: begin
                sub_req   = 1'b1;
                sub_b     = q_reg;
                state_nxt = S_FIX_R;
            end
            S_FIX_R: begin
                sub_req   = 1'b1;
                sub_b     = r_reg;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign sub_cin = sub_req;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    // Q first holds the raw dividend, then its magnitude, then shifts into
    // the unsigned quotient while R accumulates the unsigned remainder.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            q_reg       <= dividend;
                            d_reg       <= divisor;
                            neg_a       <= is_signed & dividend[WIDTH-1];
                            neg_b       <= is_signed & divisor[WIDTH-1];
                            count       <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_ABS_A: begin
                    if (neg_a) begin
                        q_reg <= sub_s;
                    end
                    r_reg <= '0;
                end
                S_ABS_B: begin
                    if (neg_b) begin
                        d_reg <= sub_s;
                    end
                end
                S_DIV: begin
                    r_reg <= trial_ok ? sub_s : shift_val;
                    q_reg <= {q_reg[WIDTH-2:0], trial_ok};
                    count <= count + CNT_W'(1);
                end
                S_FIX_Q: begin
                    quotient <= (neg_a ^ neg_b) ? sub_s : q_reg;
                end
                S_FIX_R: begin
                    remainder <= neg_a ? sub_s : r_reg;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Directed bench for div_seq_ctrl with an arithmetic reference
//               model, a shared-subtractor model and per-cycle output checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        sub_req;
    logic [31:0] sub_a;
    logic [31:0] sub_b;
    logic        sub_cin;
    logic [31:0] sub_s;
    logic        sub_cout;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int compared   = 0;
    int mismatched = 0;
    int unsigned cyc = 0;
    int unsigned t_start = 0;

    div_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .sub_req     (sub_req),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .sub_cin     (sub_cin),
        .sub_s       (sub_s),
        .sub_cout    (sub_cout),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Shared subtractor: a + ~b + cin, carry-out set when no borrow.
    assign {sub_cout, sub_s} = {1'b0, sub_a} + {1'b0, ~sub_b} + {32'd0, sub_cin};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference result {div_by_zero, remainder, quotient} from plain arithmetic.
    function automatic logic [64:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            return {1'b1, a, 32'hFFFF_FFFF};
        end
        if (!sg) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        return {1'b0, r, q};
    endfunction

    // Timeline model: ph counts cycles since the accepted start
    // (0 = idle, 1..36 = subtractor owned, 37 = done pulse).
    int          ph = 0;
    logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic        m_dbz = 1'b0, p_dbz = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ph    <= 0;
            m_q   <= '0;
            m_r   <= '0;
            m_dbz <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                {p_dbz, p_r, p_q} <= ref_div(is_signed, dividend, divisor);
                ph <= (divisor == 32'd0) ? 37 : 1;
            end
        end else if (ph == 37) begin
            m_q   <= p_q;
            m_r   <= p_r;
            m_dbz <= p_dbz;
            ph    <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    logic e_req;
    always @(negedge clock) begin
        e_req = (ph >= 1) && (ph <= 36);
        check32("busy", {31'd0, busy}, {31'd0, ph != 0});
        check32("done", {31'd0, done}, {31'd0, ph == 37});
        check32("sub_req", {31'd0, sub_req}, {31'd0, e_req});
        check32("sub_cin", {31'd0, sub_cin}, {31'd0, e_req});
        if (!e_req) begin
            check32("sub_a_idle", sub_a, 32'd0);
            check32("sub_b_idle", sub_b, 32'd0);
        end
        if (ph == 0) begin
            check32("held_quotient", quotient, m_q);
            check32("held_remainder", remainder, m_r);
            check32("held_dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
        end else if (ph == 37) begin
            check32("model_quotient", quotient, p_q);
            check32("model_remainder", remainder, p_r);
            check32("model_dbz", {31'd0, div_by_zero}, {31'd0, p_dbz});
        end
    end

    task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(posedge clock);
        #1;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start   = 1'b0;
        t_start = cyc;
    endtask

    // Latency is counted in edges from the one that samples start.
    task automatic wait_done(input string name, input logic [31:0] eq, input logic [31:0] er,
                             input logic edbz, input int elat);
        int n = 0;
        while (done !== 1'b1 && n < 80) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (done !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no done expected done within 80 cycles", name);
        end else begin
            check32({name, "_latency"}, cyc - t_start, elat);
            check32({name, "_quotient"}, quotient, eq);
            check32({name, "_remainder"}, remainder, er);
            check32({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_quotient", quotient, 32'd0);
        check32("rst_remainder", remainder, 32'd0);
        check32("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset_n = 1'b1;

        start_op(1'b0, 32'd100, 32'd7);
        wait_done("divu_100_7", 32'd14, 32'd2, 1'b0, 36);
        start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done("div_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 36);
        start_op(1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done("div_100_m7", 32'hFFFF_FFF2, 32'd2, 1'b0, 36);
        start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("divu_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 36);
        start_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("divu_max_msb", 32'd1, 32'h7FFF_FFFF, 1'b0, 36);

        // Divide by zero finishes straight away; the next real divide clears the flag.
        start_op(1'b0, 32'h0000_1234, 32'd0);
        wait_done("div_zero", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 0);
        start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 36);

        // Signed overflow, with a stray start mid-divide that must be ignored.
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (6) @(posedge clock);
        #1;
        is_signed = 1'b0;
        dividend  = 32'd5;
        divisor   = 32'd0;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("div_ovf", 32'h8000_0000, 32'd0, 1'b0, 36);

        // Reset in DIV step 10 aborts silently.
        start_op(1'b0, 32'd1000, 32'd7);
        repeat (12) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_done", {31'd0, done}, 32'd0);
        check32("abort_sub_req", {31'd0, sub_req}, 32'd0);
        check32("abort_sub_a", sub_a, 32'd0);
        check32("abort_quotient", quotient, 32'd0);
        check32("abort_remainder", remainder, 32'd0);
        check32("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
            check32("abort_no_done", {31'd0, done}, 32'd0);
        end
        reset_n = 1'b1;
        start_op(1'b0, 32'd9, 32'd3);
        wait_done("divu_9_3", 32'd3, 32'd0, 1'b0, 36);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
